serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand bit-width; legal range 2..32.
REQ-002 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 start_i  input  1  SHALL request a new subtraction; sampled only in IDLE.
REQ-005 A_i  input  WIDTH  SHALL be the minuend, captured when start is accepted.
REQ-006 B_i  input  WIDTH  SHALL be the subtrahend, captured when start is accepted.
REQ-007 Bin_i  input  1  SHALL be the borrow-in, captured when start is accepted.
REQ-008 busy_o  output  1  SHALL be high while in state SHIFT.
REQ-009 done_o  output  1  SHALL be a one-cycle pulse in state DONE.
REQ-010 D_o  output  WIDTH  SHALL be the difference A - B - Bin, modulo 2^WIDTH.
REQ-011 Bout_o  output  1  SHALL be the final borrow-out (1 = unsigned A < B + Bin).
REQ-012 Ovf_o  output  1  SHALL flag two's-complement signed overflow of the result.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE -> SHIFT when start_i = 1: latch A_i, B_i, Bin_i into shift/borrow registers; clear bit counter.
REQ-015 IDLE with start_i = 0 SHALL remain IDLE with all outputs held.
REQ-016 Each SHIFT cycle processes one bit, LSB first: d = a XOR b XOR br; br_next = (NOT a AND b) OR (NOT(a XOR b) AND br).
REQ-017 Each SHIFT cycle SHALL shift d into the result register from the MSB end and increment the counter.
REQ-018 SHIFT -> DONE after exactly WIDTH SHIFT cycles; the counter SHALL NOT wrap mid-operation.
REQ-019 On entering DONE: D_o = full result, Bout_o = final borrow, Ovf_o = (A[MSB] != B[MSB]) AND (D[MSB] != A[MSB]).
REQ-020 DONE -> IDLE unconditionally after one cycle.
REQ-021 Latency: start accepted at edge 0; done_o SHALL be high during the cycle after edge WIDTH+1.
REQ-022 start_i asserted in SHIFT or DONE SHALL be ignored; operand inputs SHALL NOT affect an operation in progress.
REQ-023 D_o, Bout_o, Ovf_o SHALL hold their last completed values until the next DONE; intermediate shift contents SHALL NOT appear on D_o.
REQ-024 Back-to-back: start_i held high SHALL start a new operation on the first IDLE cycle after DONE.

Reset
REQ-025 rst_ni low SHALL force IDLE and set busy_o = 0, done_o = 0, D_o = 0, Bout_o = 0, Ovf_o = 0, with counter and internal registers cleared.
REQ-026 Reset during SHIFT or DONE SHALL abort the operation without a done_o pulse.
REQ-027 The first start_i after reset release SHALL be accepted normally.

Verification (WIDTH = 8)
REQ-028 A=0x05, B=0x03, Bin=0 -> D_o=0x02, Bout_o=0, Ovf_o=0; done_o one cycle, 9 cycles after the accepting edge.
REQ-029 A=0x03, B=0x05, Bin=0 -> D_o=0xFE, Bout_o=1, Ovf_o=0.
REQ-030 A=0x80, B=0x01, Bin=0 -> D_o=0x7F, Bout_o=0, Ovf_o=1.
REQ-031 A=0x00, B=0x00, Bin=1 -> D_o=0xFF, Bout_o=1, Ovf_o=0.
REQ-032 Start A=0x10, B=0x01; during SHIFT drive start_i=1 with A=0xFF, B=0xFF -> D_o=0x0F, exactly one done_o, then second operation yields D_o=0x00.
REQ-033 rst_ni low for one cycle at the 4th SHIFT cycle -> all outputs 0, no done_o; then A=0x09, B=0x04 -> D_o=0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first.
// Results are published only on completion and held until the next one.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] D_o,
    output logic             Bout_o,
    output logic             Ovf_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             bout_q;
    logic             ovf_q;

    logic             last;
    logic             load;
    logic             step;
    logic             finish;
    logic             diff_bit;
    logic             br_next;

    // One full-subtractor slice on the current LSBs
    assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0])
                    | (~(a_q[0] ^ b_q[0]) & br_q);

    // Counter reaches WIDTH only after every bit has been shifted
    assign last = (cnt_q == CW'(WIDTH));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (load) begin
            a_q     <= A_i;
            b_q     <= B_i;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= Bin_i;
            a_msb_q <= A_i[WIDTH-1];
            b_msb_q <= B_i[WIDTH-1];
        end else if (step) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= {diff_bit, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CW'(1);
            br_q  <= br_next;
        end
    end

    // Visible results change only when an operation completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q    <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (finish) begin
            d_q    <= res_q;
            bout_q <= br_q;
            ovf_q  <= (a_msb_q != b_msb_q)
                   && (res_q[WIDTH-1] != a_msb_q);
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign D_o    = d_q;
    assign Bout_o = bout_q;
    assign Ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor against
// an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d_out;
    logic         bout;
    logic         ovf;

    int           tests;
    int           fails;
    logic [W-1:0] last_d;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .A_i    (a_in),
        .B_i    (b_in),
        .Bin_i  (bin_in),
        .busy_o (busy),
        .done_o (done),
        .D_o    (d_out),
        .Bout_o (bout),
        .Ovf_o  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Unsigned and signed integer arithmetic, no bit-level modelling
    task automatic model(input  logic [W-1:0] a,
                         input  logic [W-1:0] b,
                         input  logic         bi,
                         output logic [W-1:0] d,
                         output logic         bo,
                         output logic         ov);
        int u;
        int s;
        int sa;
        int sb;
        u  = int'(a) - int'(b) - int'(bi);
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = sa - sb - int'(bi);
        d  = u[W-1:0];
        bo = (u < 0);
        ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    endtask

    // Called just after the accepting edge; counts edges until done
    task automatic finish_op(input string tag,
                             input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input logic bi);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        int           lat;
        logic         held_bad;
        model(a, b, bi, ed, eb, eo);
        lat      = 0;
        held_bad = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) break;
            if (d_out !== last_d) held_bad = 1'b1;
            @(posedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, W + 1);
        check({tag, "_D"}, d_out, ed);
        check({tag, "_Bout"}, bout, eb);
        check({tag, "_Ovf"}, ovf, eo);
        check({tag, "_held"}, held_bad, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        last_d = ed;
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic bi,
                          input logic hold);
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        bin_in = bi;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            a_in = '1;
            b_in = '1;
        end else begin
            start  = 1'b0;
            a_in   = W'($urandom);
            b_in   = W'($urandom);
            bin_in = 1'($urandom_range(0, 1));
        end
        finish_op(tag, a, b, bi);
    endtask

    initial begin
        int pulses;
        tests  = 0;
        fails  = 0;
        last_d = '0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        bin_in = 1'b0;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_D", d_out, 0);
        check("rst_Bout", bout, 0);
        check("rst_Ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("r028", 8'h05, 8'h03, 1'b0, 1'b0);
        run_op("r029", 8'h03, 8'h05, 1'b0, 1'b0);
        run_op("r031", 8'h00, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op("rand", W'($urandom), W'($urandom),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // Start held with junk operands during the operation
        run_op("r032a", 8'h10, 8'h01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op("r032b", 8'hFF, 8'hFF, 1'b0);

        run_op("r030", 8'h80, 8'h01, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("idle_hold_D", d_out, 8'h7F);
        check("idle_hold_Ovf", ovf, 1);

        // Abort in the fourth shift cycle
        @(negedge clk);
        a_in  = 8'h20;
        b_in  = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_D", d_out, 0);
        check("abort_Bout", bout, 0);
        check("abort_Ovf", ovf, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        last_d = '0;
        run_op("r033", 8'h09, 8'h04, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
